// File: rtl/nvi_uart_rx.sv
// 8051-compatible UART receive engine for serial modes 1/2/3: 16x oversampling,
// 3-sample majority voting, REN/SM2/RI acceptance and sticky framing error.
module nvi_uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_x16_tick,
  input  logic       us_rx,
  input  logic [1:0] mode,
  input  logic       sm2,
  input  logic       ren,
  input  logic       ri_clr,
  input  logic       fe_clr,
  output logic [7:0] sbuf_rdata,
  output logic       rb8,
  output logic       ri,
  output logic       fe,
  output logic       rx_busy
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    BIT9  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [SYNC_N-1:0] sync_reg;
  logic              rx_s;
  logic              rx_prev_reg;
  logic              rx_fall;

  logic [3:0] scnt_reg;
  logic [3:0] scnt_inc;
  logic [2:0] bcnt_reg;
  logic [1:0] mode_reg;
  logic       s7_reg;
  logic       s8_reg;
  logic [7:0] shift_reg;
  logic       b9_reg;

  logic [7:0] sbuf_reg;
  logic       rb8_reg;
  logic       ri_reg;
  logic       fe_reg;

  logic wrap;
  logic at7;
  logic at8;
  logic at9;
  logic maj;
  logic x_bit;

  logic start_go;
  logic shift_en;
  logic b9_en;
  logic bit_end;
  logic decide;
  logic accept;
  logic fe_set;

  // Synchronizer chain plus one flop for falling-edge detection; both idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg    <= '1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[SYNC_N-2:0], us_rx};
      rx_prev_reg <= rx_s;
    end
  end

  assign rx_s    = sync_reg[SYNC_N-1];
  assign rx_fall = rx_prev_reg & ~rx_s;

  // Sample positions refer to the counter value reached on the current tick.
  assign scnt_inc = scnt_reg + 4'd1;
  assign wrap     = baud_x16_tick && (scnt_reg == 4'd15);
  assign at7      = baud_x16_tick && (scnt_inc == 4'd7);
  assign at8      = baud_x16_tick && (scnt_inc == 4'd8);
  assign at9      = baud_x16_tick && (scnt_inc == 4'd9);
  assign maj      = (s7_reg & s8_reg) | (s7_reg & rx_s) | (s8_reg & rx_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ren && (mode != 2'b00) && rx_fall) state_next = START;
      end
      START: begin
        if (!ren)            state_next = IDLE;
        else if (at9 && maj) state_next = IDLE;
        else if (wrap)       state_next = DATA;
      end
      DATA: begin
        if (!ren) begin
          state_next = IDLE;
        end else if (wrap && (bcnt_reg == 3'd7)) begin
          state_next = (mode_reg == 2'b01) ? STOP : BIT9;
        end
      end
      BIT9: begin
        if (!ren)      state_next = IDLE;
        else if (wrap) state_next = STOP;
      end
      STOP: begin
        if (!ren || at9) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_busy  = (state_reg != IDLE);
    start_go = (state_reg == IDLE) && (state_next == START);
    bit_end  = (state_reg == DATA) && wrap;
    shift_en = (state_reg == DATA) && ren && at9;
    b9_en    = (state_reg == BIT9) && ren && at9;
    decide   = (state_reg == STOP) && ren && at9;
    x_bit    = (mode_reg == 2'b01) ? maj : b9_reg;
    // RI is tested before any same-cycle ri_clr takes effect.
    accept   = decide && !ri_reg && (!sm2 || x_bit);
    fe_set   = decide && !maj;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt_reg  <= 4'd0;
      bcnt_reg  <= 3'd0;
      mode_reg  <= 2'b00;
      s7_reg    <= 1'b1;
      s8_reg    <= 1'b1;
      shift_reg <= 8'h00;
      b9_reg    <= 1'b0;
    end else begin
      if (start_go) begin
        scnt_reg <= 4'd0;
        bcnt_reg <= 3'd0;
        mode_reg <= mode;
      end else begin
        if (baud_x16_tick) scnt_reg <= scnt_inc;
        if (bit_end)       bcnt_reg <= bcnt_reg + 3'd1;
      end
      if (at7)      s7_reg    <= rx_s;
      if (at8)      s8_reg    <= rx_s;
      if (shift_en) shift_reg <= {maj, shift_reg[7:1]};
      if (b9_en)    b9_reg    <= maj;
    end
  end

  // SFR-visible flags: set has priority over the clear pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sbuf_reg <= 8'h00;
      rb8_reg  <= 1'b0;
      ri_reg   <= 1'b0;
      fe_reg   <= 1'b0;
    end else begin
      if (accept) begin
        sbuf_reg <= shift_reg;
        rb8_reg  <= x_bit;
      end
      if (accept)      ri_reg <= 1'b1;
      else if (ri_clr) ri_reg <= 1'b0;
      if (fe_set)      fe_reg <= 1'b1;
      else if (fe_clr) fe_reg <= 1'b0;
    end
  end

  assign sbuf_rdata = sbuf_reg;
  assign rb8        = rb8_reg;
  assign ri         = ri_reg;
  assign fe         = fe_reg;

endmodule

// File: tb/tb_nvi_uart_rx.sv
// Self-checking bench for nvi_uart_rx: directed scenarios plus random frames
// compared against a frame-level model of the SCON receive rules.
`timescale 1ns/1ps
module tb_nvi_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       us_rx = 1'b1;
  logic [1:0] mode = 2'b01;
  logic       sm2 = 1'b0;
  logic       ren = 1'b1;
  logic       ri_clr = 1'b0;
  logic       fe_clr = 1'b0;
  logic [7:0] sbuf_rdata;
  logic       rb8;
  logic       ri;
  logic       fe;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;

  // Frame-level reference state.
  logic [7:0] m_sbuf = 8'h00;
  logic       m_rb8 = 1'b0;
  logic       m_ri = 1'b0;
  logic       m_fe = 1'b0;

  nvi_uart_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .baud_x16_tick(tick), .us_rx(us_rx),
    .mode(mode), .sm2(sm2), .ren(ren), .ri_clr(ri_clr), .fe_clr(fe_clr),
    .sbuf_rdata(sbuf_rdata), .rb8(rb8), .ri(ri), .fe(fe), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // 16x tick: one clk high out of every five.
  initial begin
    forever begin
      repeat (4) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // Returns 2 ns after the DUT consumed the next tick; optionally pulses ri_clr on it.
  task automatic wait_tick(input bit clr);
    while (tick !== 1'b1) begin
      @(posedge clk);
      #2;
    end
    ri_clr = clr;
    @(posedge clk);
    #2;
    ri_clr = 1'b0;
  endtask

  task automatic clear_ri();
    ri_clr = 1'b1;
    @(posedge clk);
    #2;
    ri_clr = 1'b0;
    m_ri = 1'b0;
  endtask

  // Acceptance rules applied to a whole frame.
  task automatic model_frame(input int md, input bit sm2_v, input logic [7:0] data,
                             input bit b9, input bit stop, input bit clr_dec);
    bit x;
    x = (md == 1) ? stop : b9;
    if (!m_ri && (!sm2_v || x)) begin
      m_sbuf = data;
      m_rb8  = x;
      m_ri   = 1'b1;
    end else if (clr_dec) begin
      m_ri = 1'b0;
    end
    if (!stop) m_fe = 1'b1;
  endtask

  // Drives one frame; dec_tick is the tick (counted from the start edge) at which rx_busy fell.
  task automatic send_frame(input int md, input logic [7:0] data, input bit b9, input bit stop,
                            input int noise_bit, input int abort_bit, input bit clr_dec,
                            output int dec_tick);
    logic [10:0] bits;
    int nbits;
    int exp_dec;
    int k;
    bit busy_seen;
    nbits = (md == 1) ? 10 : 11;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (md == 1) begin
      bits[9] = stop;
    end else begin
      bits[9] = b9;
      bits[10] = stop;
    end
    exp_dec = 16 * (nbits - 1) + 9;
    dec_tick = -1;
    k = 0;
    busy_seen = 1'b0;
    mode = md[1:0];
    wait_tick(1'b0);
    for (int b = 0; b < nbits; b++) begin
      for (int t = 0; t < 16; t++) begin
        us_rx = bits[b] ^ ((b == noise_bit) && (t == 7));
        if ((b == abort_bit) && (t == 4)) begin
          ren = 1'b0;
          @(posedge clk);
          #2;
          checks++;
          if (rx_busy !== 1'b0 || {sbuf_rdata, rb8, ri, fe} !== {m_sbuf, m_rb8, m_ri, m_fe}) begin
            errors++;
            $display("FAIL ren_abort: busy=%b sbuf=%h rb8=%b ri=%b fe=%b, want busy=0 sbuf=%h rb8=%b ri=%b fe=%b",
                     rx_busy, sbuf_rdata, rb8, ri, fe, m_sbuf, m_rb8, m_ri, m_fe);
          end
        end
        wait_tick(clr_dec && ((k + 1) == exp_dec));
        k++;
        if (rx_busy) busy_seen = 1'b1;
        else if (busy_seen && dec_tick < 0) dec_tick = k;
      end
    end
    us_rx = 1'b1;
    repeat (3) wait_tick(1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({sbuf_rdata, rb8, ri, fe, rx_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: sbuf=%h rb8=%b ri=%b fe=%b busy=%b, want all zero",
               sbuf_rdata, rb8, ri, fe, rx_busy);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_busy_latency();
    int n;
    wait_tick(1'b0);
    us_rx = 1'b0;
    n = 0;
    while (rx_busy !== 1'b1 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    us_rx = 1'b1;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL busy_latency: rx_busy rose after %0d clk, want 3", n);
    end
    repeat (16) wait_tick(1'b0);
    checks++;
    if (rx_busy !== 1'b0 || ri !== m_ri) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b ri=%b, want busy=0 ri=%b", rx_busy, ri, m_ri);
    end
  endtask

  task automatic test_false_start();
    bit mid_busy;
    wait_tick(1'b0);
    us_rx = 1'b0;
    repeat (4) wait_tick(1'b0);
    us_rx = 1'b1;
    wait_tick(1'b0);
    mid_busy = rx_busy;
    repeat (7) wait_tick(1'b0);
    checks++;
    if (mid_busy !== 1'b1 || rx_busy !== 1'b0 ||
        {sbuf_rdata, rb8, ri, fe} !== {m_sbuf, m_rb8, m_ri, m_fe}) begin
      errors++;
      $display("FAIL false_start: busy_mid=%b busy_end=%b sbuf=%h ri=%b, want 1 0 sbuf=%h ri=%b",
               mid_busy, rx_busy, sbuf_rdata, ri, m_sbuf, m_ri);
    end
  endtask

  task automatic test_mode0();
    bit any_busy;
    any_busy = 1'b0;
    mode = 2'b00;
    wait_tick(1'b0);
    us_rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_tick(1'b0);
      if (rx_busy) any_busy = 1'b1;
    end
    us_rx = 1'b1;
    repeat (2) wait_tick(1'b0);
    mode = 2'b01;
    checks++;
    if (any_busy !== 1'b0) begin
      errors++;
      $display("FAIL mode00_idle: busy seen=%b, want 0", any_busy);
    end
  endtask

  task automatic test_mode1_basic();
    int dec;
    sm2 = 1'b0;
    send_frame(1, 8'hA5, 1'b0, 1'b1, -1, -1, 1'b0, dec);
    model_frame(1, sm2, 8'hA5, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dec !== 153) begin
      errors++;
      $display("FAIL a5_latency: decided at tick %0d, want 153", dec);
    end
    checks++;
    if ({sbuf_rdata, rb8, ri, fe} !== {8'hA5, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL a5_data: sbuf=%h rb8=%b ri=%b fe=%b, want a5 1 1 0", sbuf_rdata, rb8, ri, fe);
    end
  endtask

  task automatic test_noise();
    int dec;
    clear_ri();
    send_frame(1, 8'h3C, 1'b0, 1'b1, 3, -1, 1'b0, dec);
    model_frame(1, sm2, 8'h3C, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sbuf_rdata, rb8, ri, fe} !== {m_sbuf, m_rb8, m_ri, m_fe} || sbuf_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL noise_vote: sbuf=%h rb8=%b ri=%b fe=%b, want sbuf=3c rb8=%b ri=%b fe=%b",
               sbuf_rdata, rb8, ri, fe, m_rb8, m_ri, m_fe);
    end
  endtask

  task automatic test_multiproc();
    int dec;
    clear_ri();
    sm2 = 1'b1;
    send_frame(3, 8'h42, 1'b0, 1'b1, -1, -1, 1'b0, dec);
    model_frame(3, sm2, 8'h42, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dec !== 169 || ri !== 1'b0 || sbuf_rdata !== m_sbuf) begin
      errors++;
      $display("FAIL sm2_reject: tick=%0d ri=%b sbuf=%h, want tick=169 ri=0 sbuf=%h", dec, ri, sbuf_rdata, m_sbuf);
    end
    send_frame(3, 8'h42, 1'b1, 1'b1, -1, -1, 1'b0, dec);
    model_frame(3, sm2, 8'h42, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({sbuf_rdata, rb8, ri} !== {8'h42, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sm2_accept: sbuf=%h rb8=%b ri=%b, want 42 1 1", sbuf_rdata, rb8, ri);
    end
    sm2 = 1'b0;
  endtask

  task automatic test_ri_busy();
    int dec;
    clear_ri();
    send_frame(1, 8'h11, 1'b0, 1'b1, -1, -1, 1'b0, dec);
    model_frame(1, sm2, 8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(1, 8'h22, 1'b0, 1'b1, -1, -1, 1'b0, dec);
    model_frame(1, sm2, 8'h22, 1'b0, 1'b1, 1'b0);
    checks++;
    if (sbuf_rdata !== 8'h11 || ri !== 1'b1) begin
      errors++;
      $display("FAIL ri_busy_hold: sbuf=%h ri=%b, want 11 1", sbuf_rdata, ri);
    end
    send_frame(1, 8'h33, 1'b0, 1'b1, -1, -1, 1'b1, dec);
    model_frame(1, sm2, 8'h33, 1'b0, 1'b1, 1'b1);
    checks++;
    if (sbuf_rdata !== 8'h11 || ri !== 1'b0 || ri !== m_ri) begin
      errors++;
      $display("FAIL ri_clr_race: sbuf=%h ri=%b, want 11 0", sbuf_rdata, ri);
    end
  endtask

  task automatic test_framing();
    int dec;
    clear_ri();
    send_frame(1, 8'h7E, 1'b0, 1'b0, -1, -1, 1'b0, dec);
    model_frame(1, sm2, 8'h7E, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({sbuf_rdata, rb8, ri, fe} !== {8'h7E, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL framing: sbuf=%h rb8=%b ri=%b fe=%b, want 7e 0 1 1", sbuf_rdata, rb8, ri, fe);
    end
    fe_clr = 1'b1;
    @(posedge clk);
    #2;
    fe_clr = 1'b0;
    m_fe = 1'b0;
    checks++;
    if (fe !== 1'b0) begin
      errors++;
      $display("FAIL fe_clr: fe=%b, want 0", fe);
    end
  endtask

  task automatic test_ren_abort();
    int dec;
    clear_ri();
    send_frame(1, 8'h99, 1'b0, 1'b1, -1, 5, 1'b0, dec);
    ren = 1'b1;
    repeat (2) wait_tick(1'b0);
    checks++;
    if (rx_busy !== 1'b0 || {sbuf_rdata, rb8, ri, fe} !== {m_sbuf, m_rb8, m_ri, m_fe}) begin
      errors++;
      $display("FAIL ren_abort_after: busy=%b sbuf=%h ri=%b fe=%b, want 0 %h %b %b",
               rx_busy, sbuf_rdata, ri, fe, m_sbuf, m_ri, m_fe);
    end
  endtask

  task automatic test_reset_abort();
    int dec;
    send_frame(1, 8'h66, 1'b0, 1'b1, -1, -1, 1'b0, dec);
    model_frame(1, sm2, 8'h66, 1'b0, 1'b1, 1'b0);
    wait_tick(1'b0);
    us_rx = 1'b0;
    repeat (30) wait_tick(1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if ({sbuf_rdata, rb8, ri, fe, rx_busy} !== 12'h000 || m_ri !== 1'b1) begin
      errors++;
      $display("FAIL reset_midframe: sbuf=%h rb8=%b ri=%b fe=%b busy=%b, want all zero",
               sbuf_rdata, rb8, ri, fe, rx_busy);
    end
    us_rx = 1'b1;
    m_sbuf = 8'h00;
    m_rb8 = 1'b0;
    m_ri = 1'b0;
    m_fe = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (4) wait_tick(1'b0);
    send_frame(1, 8'h5A, 1'b0, 1'b1, -1, -1, 1'b0, dec);
    model_frame(1, sm2, 8'h5A, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dec !== 153 || {sbuf_rdata, rb8, ri, fe} !== {8'h5A, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_abort_5a: tick=%0d sbuf=%h rb8=%b ri=%b fe=%b, want 153 5a 1 1 0",
               dec, sbuf_rdata, rb8, ri, fe);
    end
  endtask

  task automatic test_random();
    int dec;
    int md;
    logic [7:0] data;
    bit b9;
    bit stop;
    bit clr_dec;
    for (int i = 0; i < 8; i++) begin
      md = $urandom_range(1, 3);
      sm2 = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      b9 = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      clr_dec = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) clear_ri();
      send_frame(md, data, b9, stop, -1, -1, clr_dec, dec);
      model_frame(md, sm2, data, b9, stop, clr_dec);
      checks++;
      if (dec !== ((md == 1) ? 153 : 169) || {sbuf_rdata, rb8, ri, fe} !== {m_sbuf, m_rb8, m_ri, m_fe}) begin
        errors++;
        $display("FAIL random_%0d: md=%0d tick=%0d sbuf=%h rb8=%b ri=%b fe=%b, want sbuf=%h rb8=%b ri=%b fe=%b",
                 i, md, dec, sbuf_rdata, rb8, ri, fe, m_sbuf, m_rb8, m_ri, m_fe);
      end
    end
    sm2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_busy_latency();
    test_false_start();
    test_mode0();
    test_mode1_basic();
    test_noise();
    test_multiproc();
    test_ri_busy();
    test_framing();
    test_ren_abort();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nvi_uart_rx.md
# nvi_uart_rx

Serial-port receive engine for the MCS-51 peripheral set: the receive half of the 8051-compatible UART. It recovers frames from the `us_rx` pin in serial modes 1, 2 and 3 using 16x oversampling with 3-sample majority voting. It applies the REN/SM2/RI acceptance rules and presents SBUF/RB8/RI to the SFR layer of the peripheral block. The baud tick comes from the existing timer-1/fixed-divider baud logic; `ri_clr`/`fe_clr` come from SFR writes to SCON.

## Interface
- `SYNC_STAGES`, default 2, number of synchronizer flops on `us_rx` (minimum 2).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `baud_x16_tick`  in  1  one-`clk` pulse at 16x the bit rate; never asserted on consecutive cycles.
- `us_rx`  in  1  asynchronous serial input; idles high.
- `mode`  in  2  SCON {SM0,SM1}. 00 is unsupported and holds the receiver in IDLE; 01 selects 10-bit frames; 10/11 select 11-bit frames.
- `sm2`  in  1  multiprocessor enable.
- `ren`  in  1  receive enable.
- `ri_clr`  in  1  one-cycle pulse that clears RI.
- `fe_clr`  in  1  one-cycle pulse that clears FE.
- `sbuf_rdata`  out  8  received byte; reset 8'h00.
- `rb8`  out  1  9th data bit (modes 2/3) or stop bit (mode 1); reset 0.
- `ri`  out  1  receive-complete flag; reset 0.
- `fe`  out  1  sticky framing-error flag; reset 0.
- `rx_busy`  out  1  high while not IDLE; reset 0.

## Operation
- `us_rx` passes through `SYNC_STAGES` flops, then one edge-detect flop. `rx_s` denotes the synchronized value; its reset value is 1.
- Sample counter `scnt` is 4 bits. It advances only on `baud_x16_tick` and wraps 15->0.
- Samples are taken at `scnt` 7, 8 and 9. The bit value is the majority of the three samples and is resolved on the tick where `scnt`==9.
- `mode` is latched at start-bit detection and is used for the whole frame.
- IDLE
  - Enter START when `ren`=1, latched mode != 00, and a 1->0 transition is seen on `rx_s`.
  - On entry: `scnt`=0, bit counter `bcnt`=0.
- START
  - If the start-bit majority is 1 (false start), return to IDLE.
  - Otherwise, when `scnt` wraps 15->0, go to DATA.
- DATA
  - Data bits are shifted LSB-first into an 8-bit shift register; `bcnt` increments at each bit end (15->0 wrap).
  - After 8 bits: mode 1 goes to STOP; modes 2/3 go to BIT9.
- BIT9
  - Capture the majority into `b9`.
  - At the wrap, go to STOP.
- STOP
  - The frame is decided on the tick where `scnt`==9; return to IDLE in the next cycle. The receiver does not wait out the rest of the stop bit.
  - Accept condition: `ri`==0 AND (`sm2`==0 OR `x`==1), where `x` is the stop-bit majority in mode 1 and `b9` in modes 2/3.
  - On accept: `sbuf_rdata` = shift register; `rb8` = `x`; `ri` = 1.
  - On reject: `sbuf_rdata`, `rb8` and `ri` are unchanged.
  - Independently of accept: if the stop-bit majority is 0, `fe` = 1.
- Flag rules
  - `ri_clr` clears `ri`.
  - If the accept decision and `ri_clr` fall in the same cycle, the decision uses the pre-clear `ri`. With `ri`=1 the frame is discarded and `ri` goes to 0.
  - `fe_clr` clears `fe`. If a new FE and `fe_clr` occur in the same cycle, set wins.
- Abort
  - `ren`=0 in any non-IDLE state returns to IDLE on the next `clk`, with no flag or data update.
  - `reset` mid-frame returns all state and outputs to reset values immediately.

## Timing
- `rx_busy` rises 1 + `SYNC_STAGES` `clk` after the pin falling edge, given `ren`=1.
- Frame length is counted from the start-bit edge to the decision, in ticks:
  - 16x9 + 9 = 153 for mode 1.
  - 16x10 + 9 = 169 for modes 2/3.
- `sbuf_rdata`, `rb8`, `ri` and `fe` update registered, 1 `clk` after the deciding tick.
- `rx_busy` falls in the same cycle those outputs update.
- A new start edge is accepted from the first IDLE cycle. The edge detector requires `rx_s` to have been high, so a stuck-low line never retriggers.
- `ri_clr`/`fe_clr` take effect 1 `clk` after assertion.

## Test plan
- Mode 01, `sm2`=0, `ren`=1: send 0xA5 with stop=1 at 16 ticks/bit. Expect `sbuf_rdata`=8'hA5, `rb8`=1, `ri`=1, `fe`=0, exactly 153 ticks after the edge.
- Noise and false start:
  - Pulse `us_rx` low for 4 ticks. Expect a return to IDLE with `ri` unchanged.
  - Send 0x3C with one of the three samples of bit 2 inverted. Expect `sbuf_rdata`=8'h3C.
- Mode 11, `sm2`=1: send 0x42 with 9th bit 0. Expect no load and `ri`=0. Then send 0x42 with 9th bit 1. Expect `sbuf_rdata`=8'h42, `rb8`=1, `ri`=1.
- `ri` busy: with `ri`=1 and `sbuf_rdata`=8'h11, send 0x22. Expect `sbuf_rdata` to stay 8'h11. Then assert `ri_clr` in the exact decision cycle of a further 0x33 frame. Expect the frame to be discarded and `ri`=0.
- Framing error: mode 01, `sm2`=0, send 0x7E with stop=0. Expect `sbuf_rdata`=8'h7E, `rb8`=0, `ri`=1, `fe`=1. Then pulse `fe_clr`; expect `fe`=0 one cycle later.
- Abort paths:
  - Drop `ren` at bit 4 of a mode-01 frame. Expect `rx_busy`=0 next `clk` and no flag change.
  - Assert `reset` mid-frame. Expect all outputs at reset values.
  - After the abort, a clean 0x5A frame must be received correctly.
